// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: one-cycle latch of decoded control, operands and flags,
// with freeze (stall), flush (bubble) and a valid bit. `FORWARDING_EN adds src1/src2 indices.
module id_exe_stage_reg #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic [WIDTH-1:0]      pc_in,
  input  logic [WIDTH-1:0]      val_rn_in,
  input  logic [WIDTH-1:0]      val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [3:0]            status_in,
`ifdef FORWARDING_EN
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
`endif
  output logic                  valid_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [3:0]            exe_cmd_out,
  output logic [WIDTH-1:0]      pc_out,
  output logic [WIDTH-1:0]      val_rn_out,
  output logic [WIDTH-1:0]      val_rm_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm_24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [3:0]            status_out
);

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  b;
    logic                  s;
    logic [3:0]            exe_cmd;
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      val_rn;
    logic [WIDTH-1:0]      val_rm;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [REG_ADDR_W-1:0] dest;
    logic [3:0]            status;
`ifdef FORWARDING_EN
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
`endif
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!freeze) begin
      stage_d.valid         = valid_in;
      // Side-effecting controls are masked so a non-valid slot can never commit anything.
      stage_d.wb_en         = valid_in & wb_en_in;
      stage_d.mem_r_en      = valid_in & mem_r_en_in;
      stage_d.mem_w_en      = valid_in & mem_w_en_in;
      stage_d.b             = valid_in & b_in;
      stage_d.s             = valid_in & s_in;
      stage_d.exe_cmd       = exe_cmd_in;
      stage_d.pc            = pc_in;
      stage_d.val_rn        = val_rn_in;
      stage_d.val_rm        = val_rm_in;
      stage_d.imm           = imm_in;
      stage_d.shift_operand = shift_operand_in;
      stage_d.signed_imm_24 = signed_imm_24_in;
      stage_d.dest          = dest_in;
      stage_d.status        = status_in;
`ifdef FORWARDING_EN
      stage_d.src1          = src1_in;
      stage_d.src2          = src2_in;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign valid_out         = stage_q.valid;
  assign wb_en_out         = stage_q.wb_en;
  assign mem_r_en_out      = stage_q.mem_r_en;
  assign mem_w_en_out      = stage_q.mem_w_en;
  assign b_out             = stage_q.b;
  assign s_out             = stage_q.s;
  assign exe_cmd_out       = stage_q.exe_cmd;
  assign pc_out            = stage_q.pc;
  assign val_rn_out        = stage_q.val_rn;
  assign val_rm_out        = stage_q.val_rm;
  assign imm_out           = stage_q.imm;
  assign shift_operand_out = stage_q.shift_operand;
  assign signed_imm_24_out = stage_q.signed_imm_24;
  assign dest_out          = stage_q.dest;
  assign status_out        = stage_q.status;
`ifdef FORWARDING_EN
  assign src1_out          = stage_q.src1;
  assign src2_out          = stage_q.src2;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed plan items, then random traffic vs. a word-level model.
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, valid_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, status_in, dest_in, src1_in, src2_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;

  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [3:0]  exe_cmd_out, status_out, dest_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
`ifdef FORWARDING_EN
  logic [3:0]  src1_out, src2_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [159:0] exp_vec;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.WIDTH(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .status_in(status_in),
`ifdef FORWARDING_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1_out(src1_out), .src2_out(src2_out),
`endif
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
    .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .status_out(status_out)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // What the stage should hold after loading the current inputs.
  function automatic logic [159:0] in_vec();
    logic [4:0] ctl;
    ctl = valid_in ? {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in} : 5'b0;
    return 160'({valid_in, ctl, exe_cmd_in, pc_in, val_rn_in, val_rm_in, imm_in,
                 shift_operand_in, signed_imm_24_in, dest_in, status_in
`ifdef FORWARDING_EN
                 , src1_in, src2_in
`endif
                 });
  endfunction

  function automatic logic [159:0] obs_vec();
    return 160'({valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
                 exe_cmd_out, pc_out, val_rn_out, val_rm_out, imm_out,
                 shift_operand_out, signed_imm_24_out, dest_out, status_out
`ifdef FORWARDING_EN
                 , src1_out, src2_out
`endif
                 });
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst || flush) exp_vec = '0;
    else if (!freeze) exp_vec = in_vec();
    #1;
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    r = $urandom;
    {valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = r[6:0];
    exe_cmd_in = r[11:8]; status_in = r[15:12]; dest_in = r[19:16];
    src1_in = r[23:20]; src2_in = r[27:24];
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    r = $urandom;
    shift_operand_in = r[11:0];
    r = $urandom;
    signed_imm_24_in = r[23:0];
  endtask

  task automatic async_rst(input string tag);
    rst = 1'b1;
    #1;
    exp_vec = '0;
    chk(tag, obs_vec(), 160'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    rand_inputs();
    exp_vec = '0;
    step();
    rst = 1'b0;
    // Nonzero load, then asynchronous reset between edges.
    valid_in = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
    b_in = 1'b1; s_in = 1'b1; imm_in = 1'b1; pc_in = 32'hFFFF_FFFF;
    step();
    chk("preload", obs_vec(), exp_vec);
    #2 rst = 1'b1;
    #1 chk("rst_async", obs_vec(), 160'd0);
    step();
    chk("rst_held", obs_vec(), 160'd0);
    rst = 1'b0;

    // Directed load.
    rand_inputs();
    valid_in = 1'b1; exe_cmd_in = 4'b0010; wb_en_in = 1'b1;
    pc_in = 32'h0000_0010; val_rn_in = 32'd5; dest_in = 4'd3;
    step();
    chk("load_vec", obs_vec(), exp_vec);
    chk("load_cmd", exe_cmd_out, 4'b0010);
    chk("load_pc", pc_out, 32'h10);
    chk("load_rn", val_rn_out, 32'd5);
    chk("load_dest", dest_out, 4'd3);
    chk("load_wb", wb_en_out, 1'b1);
    chk("load_valid", valid_out, 1'b1);

    // Freeze for three cycles while inputs move.
    freeze = 1'b1; exe_cmd_in = 4'b0100; dest_in = 4'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_cmd", exe_cmd_out, 4'b0010);
      chk("frz_dest", dest_out, 4'd3);
      chk("frz_valid", valid_out, 1'b1);
    end
    freeze = 1'b0;
    step();
    chk("unfrz_cmd", exe_cmd_out, 4'b0100);
    chk("unfrz_dest", dest_out, 4'd7);

    // Flush wins over freeze.
    valid_in = 1'b1; mem_w_en_in = 1'b1; b_in = 1'b1; s_in = 1'b1;
    flush = 1'b1; freeze = 1'b1;
    step();
    chk("flush_all", obs_vec(), 160'd0);
    chk("flush_memw", mem_w_en_out, 1'b0);
    flush = 1'b0; freeze = 1'b0;

    // Non-valid slot: controls masked, data passes through.
    valid_in = 1'b0; wb_en_in = 1'b1; mem_r_en_in = 1'b1; val_rm_in = 32'hDEAD_BEEF;
    step();
    chk("bub_wb", wb_en_out, 1'b0);
    chk("bub_mr", mem_r_en_out, 1'b0);
    chk("bub_rm", val_rm_out, 32'hDEAD_BEEF);
    chk("bub_valid", valid_out, 1'b0);
    chk("bub_vec", obs_vec(), exp_vec);

    // No sign extension on the branch offset.
    valid_in = 1'b1; signed_imm_24_in = 24'h80_0001;
    step();
    chk("imm24", 160'(signed_imm_24_out), 160'h80_0001);

`ifdef FORWARDING_EN
    src1_in = 4'd2; src2_in = 4'd9;
    step();
    chk("fwd_src1", src1_out, 4'd2);
    chk("fwd_src2", src2_out, 4'd9);
    flush = 1'b1;
    step();
    chk("fwd_flush", {src1_out, src2_out}, 8'd0);
    flush = 1'b0;
`endif

    // Reset during a stall and during a flush.
    step();
    freeze = 1'b1;
    step();
    async_rst("rst_mid_frz");
    freeze = 1'b0; flush = 1'b1;
    step();
    async_rst("rst_mid_flush");
    flush = 1'b0;
    step();
    chk("post_rst_load", obs_vec(), exp_vec);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      freeze = ($urandom_range(3) == 0);
      flush  = ($urandom_range(7) == 0);
      step();
      chk("rand", obs_vec(), exp_vec);
      if ($urandom_range(31) == 0) async_rst("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
